// File: rtl/sha3_pkg.sv
// Shared types and helpers for the SHA3 digest collection path.
package sha3_pkg;

  localparam int SHA3_STATE_BITS = 1600;

  typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} sha3_mode_t;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, HOLD} coll_state_t;

  // Number of stream words that make up the digest of a given mode.
  function automatic logic [5:0] mode_words(sha3_mode_t mode, int width);
    int bits;
    case (mode)
      SHA3_224: bits = 224;
      SHA3_256: bits = 256;
      SHA3_384: bits = 384;
      default:  bits = 512;
    endcase
    return 6'(bits / width);
  endfunction

endpackage

// File: rtl/sha3_digest_collector.sv
// Assembles the SHA3 core output word stream into one MSB-first digest
// register and hands it to the host with a valid/ready handshake.
// The core cannot be stalled, so every word is either captured, drained or
// dropped (overrun while the previous digest is still unclaimed).
// Optional macro SHA3_COLLECT_STATUS_EN adds sticky err_short/err_overrun.
module sha3_digest_collector
  import sha3_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SKIP_WORDS = 0,
  parameter int DIG_W      = 512
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [1:0]       id,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic [DIG_W-1:0] digest,
  output logic [5:0]       digest_words,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             busy
`ifdef SHA3_COLLECT_STATUS_EN
  ,
  output logic             err_short,
  output logic             err_overrun
`endif
);

  coll_state_t      state, state_n;
  logic [5:0]       widx, widx_n;
  logic [5:0]       nwords, nwords_n;
  logic [DIG_W-1:0] dig, dig_n, dig_base;
  logic [DIG_W-1:0] word_msb;
  logic [5:0]       idx, n_cur;
  logic             start, proc, hs, short_set, ovr_set;
  int               pos, last_pos;

  // Word counter stops at 63 so very long bursts never wrap back into the window.
  function automatic logic [5:0] sat_inc(logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  assign word_msb     = {s_data, {(DIG_W-WIDTH){1'b0}}};
  assign digest       = dig;
  assign digest_words = nwords;
  assign digest_valid = (state == HOLD);
  assign busy         = (state == COLLECT) || (state == DRAIN);

  // Next-state and datapath: a new burst (from IDLE or a completing HOLD
  // handshake) restarts from a clean digest and the freshly sampled mode.
  always_comb begin
    state_n   = state;
    widx_n    = widx;
    nwords_n  = nwords;
    dig_n     = dig;
    start     = 1'b0;
    proc      = 1'b0;
    hs        = 1'b0;
    short_set = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE:    start = s_valid;
      COLLECT: proc  = s_valid;
      DRAIN: begin
        if (s_valid) begin
          widx_n = sat_inc(widx);
          if (s_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (digest_ready) begin
          hs      = 1'b1;
          state_n = IDLE;
          start   = s_valid;
        end else if (s_valid) begin
          ovr_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    idx      = start ? 6'd0 : widx;
    n_cur    = start ? mode_words(sha3_mode_t'(id), WIDTH) : nwords;
    dig_base = start ? '0 : dig;
    pos      = int'(idx) - SKIP_WORDS;
    last_pos = int'(n_cur) - 1;
    if (start) nwords_n = n_cur;

    if (start || proc) begin
      dig_n  = dig_base;
      if (pos >= 0 && pos <= last_pos) dig_n = dig_base | (word_msb >> (WIDTH * pos));
      widx_n = sat_inc(idx);
      if (pos == last_pos) begin
        state_n = s_last ? HOLD : DRAIN;
      end else if (s_last) begin
        state_n   = HOLD;
        short_set = 1'b1;
      end else begin
        state_n = COLLECT;
      end
    end
  end

  // State, counters and digest register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      widx   <= '0;
      nwords <= '0;
      dig    <= '0;
    end else begin
      state  <= state_n;
      widx   <= widx_n;
      nwords <= nwords_n;
      dig    <= dig_n;
    end
  end

`ifdef SHA3_COLLECT_STATUS_EN
  // Sticky status: a completed handshake clears, a same-cycle set wins.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (short_set)   err_short   <= 1'b1;
      else if (hs)     err_short   <= 1'b0;
      if (ovr_set)     err_overrun <= 1'b1;
      else if (hs)     err_overrun <= 1'b0;
    end
  end
`else
  logic unused_status;
  assign unused_status = short_set ^ ovr_set ^ hs;
`endif

endmodule

// File: tb/tb_sha3_digest_collector.sv
// Scoreboard bench: two collectors (SKIP_WORDS 0 and 4) share one stimulus
// stream; the driver queues expected digests, the monitor checks them.
module tb_sha3_digest_collector;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [1:0]  id = '0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        digest_ready = 1'b0;

  logic [511:0] dg[2];
  logic [5:0]   dw[2];
  logic         dv[2];
  logic         bz[2];
`ifdef SHA3_COLLECT_STATUS_EN
  logic         es[2];
  logic         eo[2];
`endif

  typedef struct {
    logic [511:0] d;
    logic [5:0]   w;
    logic         sh;
    logic         ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e;
  logic pv[2];
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 ACLK = ~ACLK;

  sha3_digest_collector #(.WIDTH(16), .SKIP_WORDS(0), .DIG_W(512)) u_dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn), .id(id), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .digest(dg[0]), .digest_words(dw[0]), .digest_valid(dv[0]),
    .digest_ready(digest_ready), .busy(bz[0])
`ifdef SHA3_COLLECT_STATUS_EN
    , .err_short(es[0]), .err_overrun(eo[0])
`endif
  );

  sha3_digest_collector #(.WIDTH(16), .SKIP_WORDS(4), .DIG_W(512)) u_dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .id(id), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .digest(dg[1]), .digest_words(dw[1]), .digest_valid(dv[1]),
    .digest_ready(digest_ready), .busy(bz[1])
`ifdef SHA3_COLLECT_STATUS_EN
    , .err_short(es[1]), .err_overrun(eo[1])
`endif
  );

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int nw(int mid);
    return (mid == 0) ? 14 : (mid == 1) ? 16 : (mid == 2) ? 24 : 32;
  endfunction

  // Expected digest: word k of the window is stream word skip+k, if it arrived.
  function automatic exp_t mk(int base, int len, int mid, int skip, bit ov);
    exp_t r;
    int n = nw(mid);
    r.d = '0;
    for (int k = 0; k < n; k++)
      if (skip + k < len) r.d[511-16*k -: 16] = 16'(base + skip + k);
    r.w  = 6'(n);
    r.sh = (len < skip + n);
    r.ov = ov;
    return r;
  endfunction

  // Track the cycle on which the closing word was sampled.
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (s_valid && s_last) last_cyc <= cyc;
  end

  // Monitor: compare every cycle a digest is presented, pop on handshake.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      for (int i = 0; i < 2; i++) begin
        if (dv[i]) begin
          if (!pv[i]) chk($sformatf("latency%0d", i), 512'(cyc), 512'(last_cyc + 1));
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_digest%0d actual=%h expected=none", i, dg[i]);
          end else begin
            e = (i == 0) ? q0[0] : q1[0];
            chk($sformatf("digest%0d", i), dg[i], e.d);
            chk($sformatf("words%0d", i), 512'(dw[i]), 512'(e.w));
            chk($sformatf("busy_hold%0d", i), 512'(bz[i]), 512'(0));
            if (digest_ready) begin
`ifdef SHA3_COLLECT_STATUS_EN
              chk($sformatf("err_short%0d", i), 512'(es[i]), 512'(e.sh));
              chk($sformatf("err_overrun%0d", i), 512'(eo[i]), 512'(e.ov));
`endif
              if (i == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
    end
    pv[0] <= dv[0];
    pv[1] <= dv[1];
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // One burst; id is flipped after the first word to show it is ignored.
  task automatic send_burst(int base, int len, int mid, bit hs_first, bit ov);
    q0.push_back(mk(base, len, mid, 0, ov));
    q1.push_back(mk(base, len, mid, 4, ov));
    for (int i = 0; i < len; i++) begin
      s_valid      = 1'b1;
      s_data       = 16'(base + i);
      s_last       = (i == len - 1);
      id           = (i == 0) ? 2'(mid) : ~2'(mid);
      digest_ready = hs_first && (i == 0);
      tick();
    end
    s_valid      = 1'b0;
    s_last       = 1'b0;
    digest_ready = 1'b0;
  endtask

  task automatic accept();
    repeat (2) tick();
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    tick();
  endtask

  task automatic chk_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_digest%0d", tag, i), dg[i], '0);
      chk($sformatf("%s_words%0d", tag, i), 512'(dw[i]), 512'(0));
      chk($sformatf("%s_valid%0d", tag, i), 512'(dv[i]), 512'(0));
      chk($sformatf("%s_busy%0d", tag, i), 512'(bz[i]), 512'(0));
`ifdef SHA3_COLLECT_STATUS_EN
      chk($sformatf("%s_err%0d", tag, i), 512'({es[i], eo[i]}), 512'(0));
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] hand0, hand1;
    hand0 = 256'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f;
    hand1 = 256'h0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010_0011_0012_0013;

    repeat (2) @(posedge ACLK);
    #3;
    chk_zero("reset");
    ARESETn = 1'b1;
    tick();

    // SHA3-256, 100 words: hand-computed digests for both skip settings.
    q0.push_back('{d: {hand0, 256'h0}, w: 6'd16, sh: 1'b0, ov: 1'b0});
    q1.push_back('{d: {hand1, 256'h0}, w: 6'd16, sh: 1'b0, ov: 1'b0});
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      s_last  = (i == 99);
      id      = (i == 0) ? 2'd1 : 2'd2;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    accept();

    // Remaining modes over the same burst.
    send_burst(0, 100, 0, 1'b0, 1'b0); accept();
    send_burst(0, 100, 2, 1'b0, 1'b0); accept();
    send_burst(0, 100, 3, 1'b0, 1'b0); accept();

    // Short burst: 10 words in SHA3-512 mode.
    send_burst(0, 10, 3, 1'b0, 1'b0); accept();

    // Overrun in HOLD, then the next burst starts on the handshake cycle.
    send_burst(16'h100, 20, 1, 1'b0, 1'b1);
    repeat (2) tick();
    s_valid = 1'b1;
    s_data  = 16'hdead;
    tick();
    s_valid = 1'b0;
    tick();
    send_burst(16'h200, 20, 2, 1'b1, 1'b0);
    accept();

    // Reset while word 7 of a burst is on the bus.
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(16'h300 + i);
      id      = 2'd1;
      tick();
    end
    s_data = 16'h307;
    #2;
    ARESETn = 1'b0;
    #1;
    chk_zero("midreset");
    s_valid = 1'b0;
    @(posedge ACLK);
    #3;
    ARESETn = 1'b1;
    tick();
    send_burst(16'h400, 20, 0, 1'b0, 1'b0);
    accept();

    repeat (3) tick();
    chk("sb_drained0", 512'(q0.size()), 512'(0));
    chk("sb_drained1", 512'(q1.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_digest_collector.md
Name: sha3_digest_collector

Overview:
- Downstream stage of the AXI SHA3 core. Consumes the core's 16-bit output word stream (Ready/Last qualified) and assembles the digest for the selected mode (SHA3-224/256/384/512) into one wide register.
- Presents the digest with a valid/ready handshake to the host-side register or DMA interface.
- The core output has no backpressure, so the collector must absorb or flag every word.

Parameters:
- WIDTH, 16, stream word width in bits; must divide 224.
- SKIP_WORDS, 0, words discarded at the start of each burst before capture begins (0..15).
- DIG_W, 512, digest register width in bits.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- id  in  2  mode select: 0=224, 1=256, 2=384, 3=512. Sampled on the first word of a burst.
- s_data  in  WIDTH  output word from the SHA core (Mode_out).
- s_valid  in  1  word valid (core Ready).
- s_last  in  1  last word of burst (core Last), qualified by s_valid.
- digest  out  DIG_W  assembled digest. First captured word occupies the MSBs; bits beyond the mode length are 0.
- digest_words  out  6  captured word count for the mode: 14/16/24/32.
- digest_valid  out  1  digest is available.
- digest_ready  in  1  consumer accepts the digest.
- busy  out  1  high in COLLECT or DRAIN.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE.
  - digest=0, digest_words=0, digest_valid=0, busy=0, counters=0.
- N (words to capture) = 14/16/24/32 for id 0/1/2/3, i.e. bits/WIDTH. Latched with id on the first word of a burst.
- Word counter widx counts accepted words in the burst. Capture when SKIP_WORDS <= widx < SKIP_WORDS+N. Captured word k goes to digest[DIG_W-1-WIDTH*k -: WIDTH].
- States:
  - IDLE: s_valid=1 → clear digest, latch id/N, process word 0. Next state is COLLECT, or HOLD if s_last is also set.
  - COLLECT: each s_valid processes one word.
    - After word SKIP_WORDS+N-1 is captured: go to DRAIN if !s_last, or HOLD if s_last.
    - s_last before N words are captured: go to HOLD. The digest holds the partial words, the rest are zero, and err_short is set (see optional feature).
  - DRAIN: discard words; s_valid&&s_last → HOLD.
  - HOLD: digest_valid=1 and digest/digest_words stable. digest_ready=1 → digest_valid=0 next cycle, state=IDLE.
- Latency: digest_valid rises on the cycle after the s_last word is sampled.
- Simultaneous events in HOLD:
  - s_valid without digest_ready: word dropped, err_overrun set, state unchanged.
  - s_valid together with digest_ready: handshake completes, and that word is the first word of a new burst (IDLE processing applied in the same edge).
- digest_ready outside HOLD is ignored.
- widx saturates at 63. Bursts longer than 63 words stay in DRAIN with no wrap-around.
- id changes mid-burst have no effect.
- Reset mid-burst abandons the burst and clears all state immediately.

Optional Feature:
- Macro SHA3_COLLECT_STATUS_EN.
- Defined: adds outputs err_short (1) and err_overrun (1).
  - Both are sticky flags, set as described above.
  - Both are cleared by reset or by a completed digest handshake, unless the same cycle sets them again; set wins.
- Undefined: the ports and flags are absent. Short bursts and overrun drops behave identically but are not reported.

Decomposition:
- Package sha3_pkg:
  - enum sha3_mode_t {SHA3_224, SHA3_256, SHA3_384, SHA3_512}.
  - Function mode_words(mode, width) returning N.
  - State enum coll_state_t {IDLE, COLLECT, DRAIN, HOLD}.
  - Constant SHA3_STATE_BITS=1600.
- No sub-module: a single FSM plus datapath is sufficient.

Test Plan:
- id=1, SKIP_WORDS=0, a 100-word burst with words 16'h0000..16'h0063 and s_last on word 99:
  - digest[511:256] = 0000_0001_..._000F, lower bits 0, digest_words=16.
  - digest_valid rises 1 cycle after the last word.
- id=0, then id=2, then id=3 over the same burst:
  - digest_words = 14 / 24 / 32.
  - For id=0 the digest MSBs are words 0..13 and bits [287:0] are 0.
- SKIP_WORDS=4, id=1: the digest starts with word 16'h0004 and ends with 16'h0013.
- 10-word burst with id=3 and s_last on word 9:
  - HOLD reached, digest_words=32, words 0..9 present, remainder 0.
  - err_short=1 (macro defined).
- Overrun and back-to-back:
  - In HOLD, s_valid without ready → err_overrun=1 and the digest is unchanged.
  - Next burst's first word arrives together with digest_ready → that word is captured as word 0 of the new digest.
- Reset mid-burst: ARESETn low at word 7 → all outputs 0 immediately; a fresh burst after release collects correctly.
